// File: rtl/axi_rd_bridge.sv
// Instruction-fetch to AXI read bridge.
// Converts a level-held fetch request into a single-beat AXI read and returns
// the data as a one-cycle data_ok pulse. Exactly one read is in flight at a time.
// A pipeline flush (cancel) lets the AXI read finish but drops its result.
module axi_rd_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cancel,
    output logic              stall,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic                cancelled_r, cancelled_s;
    logic                arvalid_r, arvalid_s;
    logic                rready_r, rready_s;
    logic                data_ok_r, data_ok_s;
    logic                err_r, err_s;
    logic [ADDR_W-1:0]   araddr_r, araddr_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cancelled_r <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            data_ok_r   <= 1'b0;
            err_r       <= 1'b0;
            araddr_r    <= {ADDR_W{1'b0}};
            rdata_r     <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cancelled_r <= cancelled_s;
            arvalid_r   <= arvalid_s;
            rready_r    <= rready_s;
            data_ok_r   <= data_ok_s;
            err_r       <= err_s;
            araddr_r    <= araddr_s;
            rdata_r     <= rdata_s;
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_s     = state_r;
        cancelled_s = cancelled_r;
        arvalid_s   = arvalid_r;
        rready_s    = rready_r;
        data_ok_s   = 1'b0;
        err_s       = 1'b0;
        araddr_s    = araddr_r;
        rdata_s     = rdata_r;
        case (state_r)
            IDLE: begin
                cancelled_s = 1'b0;
                // While data_ok is high the held req still belongs to the
                // fetch just completed, so it must not start a new read.
                if (req && !data_ok_r) begin
                    araddr_s  = addr;
                    arvalid_s = 1'b1;
                    state_s   = ADDR;
                end else begin
                    state_s   = IDLE;
                end
            end
            ADDR: begin
                cancelled_s = cancelled_r | cancel;
                if (arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = DATA;
                end else begin
                    state_s   = ADDR;
                end
            end
            DATA: begin
                cancelled_s = cancelled_r | cancel;
                if (rvalid) begin
                    rready_s    = 1'b0;
                    state_s     = IDLE;
                    cancelled_s = 1'b0;
                    // A cancel arriving with rvalid still kills the result.
                    if (!cancelled_r && !cancel) begin
                        data_ok_s = 1'b1;
                        err_s     = (rresp != 2'b00);
                        rdata_s   = rdata;
                    end else begin
                        data_ok_s = 1'b0;
                        err_s     = 1'b0;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s     = IDLE;
                cancelled_s = 1'b0;
                arvalid_s   = 1'b0;
                rready_s    = 1'b0;
            end
        endcase
    end

    assign stall   = (state_r != IDLE) | (req & ~data_ok_r);
    assign data_ok = data_ok_r;
    assign err     = err_r;
    assign rdata_o = rdata_r;
    assign arvalid = arvalid_r;
    assign araddr  = araddr_r;
    assign rready  = rready_r;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;

endmodule

// File: tb/tb_axi_rd_bridge.sv
// Directed self-checking bench for axi_rd_bridge.
// Inputs change at the falling edge; outputs are checked 1 time unit later.
module tb_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        cancel;
    logic        stall;
    logic        data_ok;
    logic [31:0] rdata_o;
    logic        err;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int checks   = 0;
    int failures = 0;
    int hs_count;
    int dok_count;

    axi_rd_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .cancel(cancel),
        .stall(stall), .data_ok(data_ok), .rdata_o(rdata_o), .err(err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Tally AR handshakes and data_ok pulses in the current cycle.
    task automatic sample_counts();
        if (arvalid && arready) hs_count++;
        if (data_ok) dok_count++;
    endtask

    // Zero-wait read from IDLE; returns in the data_ok cycle with req still high.
    task automatic run_zero_wait(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] r, input logic idle_cancel);
        req = 1'b1; addr = a; arready = 1'b1; rvalid = 1'b1; rdata = d; rresp = r;
        cancel = idle_cancel;
        next_cycle();
        cancel = 1'b0;
        next_cycle();
        next_cycle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; addr = 32'h0; cancel = 1'b0; arready = 1'b0;
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        next_cycle(); next_cycle();
        #1;
        checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b exp=0", rready); end
        checks++; if (data_ok !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_dok_err got=%b%b exp=00", data_ok, err); end
        checks++; if (araddr !== 32'h0 || rdata_o !== 32'h0) begin failures++; $display("FAIL reset_regs araddr=%h rdata_o=%h exp=0", araddr, rdata_o); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (arlen !== 8'd0 || arsize !== 3'b010) begin failures++; $display("FAIL const_len_size got=%h/%b exp=00/010", arlen, arsize); end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_zero_wait();
        req = 1'b1; addr = 32'hBFC0_0000; arready = 1'b1; rvalid = 1'b1;
        rdata = 32'h3C08_BFC0; rresp = 2'b00;
        #1;
        checks++; if (stall !== 1'b1 || arvalid !== 1'b0) begin failures++; $display("FAIL zw_c0 stall=%b arvalid=%b exp=1/0", stall, arvalid); end
        next_cycle(); #1;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0000 || rready !== 1'b0) begin failures++; $display("FAIL zw_c1 arvalid=%b araddr=%h rready=%b exp=1/bfc00000/0", arvalid, araddr, rready); end
        next_cycle(); #1;
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1 || data_ok !== 1'b0) begin failures++; $display("FAIL zw_c2 arvalid=%b rready=%b data_ok=%b exp=0/1/0", arvalid, rready, data_ok); end
        next_cycle(); #1;
        checks++; if (data_ok !== 1'b1 || err !== 1'b0 || rdata_o !== 32'h3C08_BFC0) begin failures++; $display("FAIL zw_c3 data_ok=%b err=%b rdata_o=%h exp=1/0/3c08bfc0", data_ok, err, rdata_o); end
        checks++; if (stall !== 1'b0 || rready !== 1'b0) begin failures++; $display("FAIL zw_c3_stall stall=%b rready=%b exp=0/0", stall, rready); end
        req = 1'b0; rvalid = 1'b0; arready = 1'b0;
        next_cycle(); #1;
        checks++; if (data_ok !== 1'b0 || arvalid !== 1'b0) begin failures++; $display("FAIL zw_c4 data_ok=%b arvalid=%b exp=0/0", data_ok, arvalid); end
    endtask

    task automatic test_back_pressure();
        hs_count = 0; dok_count = 0;
        req = 1'b1; addr = 32'h1000_0010; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            #1; sample_counts();
            checks++; if (arvalid !== 1'b1 || araddr !== 32'h1000_0010 || stall !== 1'b1) begin failures++; $display("FAIL bp_addr_wait%0d arvalid=%b araddr=%h stall=%b exp=1/10000010/1", i, arvalid, araddr, stall); end
            addr = 32'h5555_0000;
            next_cycle();
        end
        arready = 1'b1;
        #1; sample_counts();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h1000_0010) begin failures++; $display("FAIL bp_ar_hs arvalid=%b araddr=%h exp=1/10000010", arvalid, araddr); end
        next_cycle();
        arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; sample_counts();
            checks++; if (rready !== 1'b1 || data_ok !== 1'b0 || stall !== 1'b1 || arvalid !== 1'b0) begin failures++; $display("FAIL bp_data_wait%0d rready=%b data_ok=%b stall=%b arvalid=%b exp=1/0/1/0", i, rready, data_ok, stall, arvalid); end
            next_cycle();
        end
        rvalid = 1'b1; rdata = 32'h1234_5678;
        #1; sample_counts();
        checks++; if (stall !== 1'b1 || rready !== 1'b1) begin failures++; $display("FAIL bp_r_hs stall=%b rready=%b exp=1/1", stall, rready); end
        next_cycle(); #1; sample_counts();
        checks++; if (data_ok !== 1'b1 || rdata_o !== 32'h1234_5678) begin failures++; $display("FAIL bp_dok data_ok=%b rdata_o=%h exp=1/12345678", data_ok, rdata_o); end
        req = 1'b0; rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1; sample_counts();
        end
        checks++; if (dok_count !== 1) begin failures++; $display("FAIL bp_dok_count got=%0d exp=1", dok_count); end
        checks++; if (hs_count !== 1) begin failures++; $display("FAIL bp_hs_count got=%0d exp=1", hs_count); end
    endtask

    task automatic test_error();
        run_zero_wait(32'h0000_0200, 32'hDEAD_BEEF, 2'b10, 1'b0);
        checks++; if (data_ok !== 1'b1 || err !== 1'b1 || rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL err_pulse data_ok=%b err=%b rdata_o=%h exp=1/1/deadbeef", data_ok, err, rdata_o); end
        req = 1'b0; rvalid = 1'b0; rresp = 2'b00;
        next_cycle(); #1;
        checks++; if (data_ok !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL err_one_cycle data_ok=%b err=%b exp=0/0", data_ok, err); end
    endtask

    task automatic test_cancel();
        req = 1'b1; addr = 32'h0000_0100; arready = 1'b1; rvalid = 1'b0; rresp = 2'b01;
        next_cycle(); next_cycle();
        cancel = 1'b1; req = 1'b0;
        #1;
        checks++; if (rready !== 1'b1) begin failures++; $display("FAIL cancel_rready got=%b exp=1", rready); end
        next_cycle();
        cancel = 1'b0; rvalid = 1'b1; rdata = 32'hAAAA_5555;
        #1;
        checks++; if (rready !== 1'b1 || data_ok !== 1'b0) begin failures++; $display("FAIL cancel_still_rready rready=%b data_ok=%b exp=1/0", rready, data_ok); end
        next_cycle();
        rvalid = 1'b0;
        #1;
        checks++; if (data_ok !== 1'b0 || err !== 1'b0 || rdata_o !== 32'hDEAD_BEEF || rready !== 1'b0) begin failures++; $display("FAIL cancel_suppress data_ok=%b err=%b rdata_o=%h rready=%b exp=0/0/deadbeef/0", data_ok, err, rdata_o, rready); end
        // next fetch, with a cancel pulse in IDLE that must be harmless
        run_zero_wait(32'h2000_0000, 32'h0BAD_F00D, 2'b00, 1'b1);
        checks++; if (data_ok !== 1'b1 || rdata_o !== 32'h0BAD_F00D) begin failures++; $display("FAIL cancel_next data_ok=%b rdata_o=%h exp=1/0badf00d", data_ok, rdata_o); end
        req = 1'b0; rvalid = 1'b0;
        next_cycle();
        // cancel coinciding with rvalid
        req = 1'b1; addr = 32'h2000_0004; arready = 1'b1; rvalid = 1'b0; rresp = 2'b00;
        next_cycle(); next_cycle();
        cancel = 1'b1; rvalid = 1'b1; rdata = 32'h5555_5555; req = 1'b0;
        next_cycle();
        cancel = 1'b0; rvalid = 1'b0;
        #1;
        checks++; if (data_ok !== 1'b0 || rdata_o !== 32'h0BAD_F00D) begin failures++; $display("FAIL cancel_with_rvalid data_ok=%b rdata_o=%h exp=0/0badf00d", data_ok, rdata_o); end
        next_cycle(); #1;
        checks++; if (arvalid !== 1'b0 || stall !== 1'b0 || rready !== 1'b0) begin failures++; $display("FAIL cancel_idle arvalid=%b stall=%b rready=%b exp=0/0/0", arvalid, stall, rready); end
    endtask

    task automatic test_reset_mid();
        req = 1'b1; addr = 32'h3000_0000; arready = 1'b1; rvalid = 1'b0; rresp = 2'b00;
        next_cycle(); next_cycle();
        #1;
        checks++; if (rready !== 1'b1) begin failures++; $display("FAIL rstmid_in_data rready=%b exp=1", rready); end
        rst = 1'b1; req = 1'b0;
        #1;
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || data_ok !== 1'b0 || err !== 1'b0 || araddr !== 32'h0 || rdata_o !== 32'h0 || stall !== 1'b0) begin failures++; $display("FAIL rstmid_async arvalid=%b rready=%b data_ok=%b err=%b araddr=%h rdata_o=%h stall=%b exp=all 0", arvalid, rready, data_ok, err, araddr, rdata_o, stall); end
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b1; rdata = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            checks++; if (data_ok !== 1'b0 || rready !== 1'b0 || rdata_o !== 32'h0) begin failures++; $display("FAIL rstmid_late_rvalid%0d data_ok=%b rready=%b rdata_o=%h exp=0/0/0", i, data_ok, rready, rdata_o); end
        end
        rvalid = 1'b0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        hs_count = 0; dok_count = 0;
        req = 1'b1; addr = 32'h0040_0000; arready = 1'b1; rvalid = 1'b1;
        rdata = 32'h1111_1111; rresp = 2'b00;
        #1; sample_counts();
        next_cycle(); #1; sample_counts();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h0040_0000) begin failures++; $display("FAIL b2b_ar1 arvalid=%b araddr=%h exp=1/00400000", arvalid, araddr); end
        next_cycle(); #1; sample_counts();
        next_cycle(); #1; sample_counts();
        checks++; if (data_ok !== 1'b1 || rdata_o !== 32'h1111_1111 || arvalid !== 1'b0) begin failures++; $display("FAIL b2b_dok1 data_ok=%b rdata_o=%h arvalid=%b exp=1/11111111/0", data_ok, rdata_o, arvalid); end
        next_cycle();
        addr = 32'h0040_0004; rdata = 32'h2222_2222;
        #1; sample_counts();
        checks++; if (arvalid !== 1'b0 || data_ok !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL b2b_gap arvalid=%b data_ok=%b stall=%b exp=0/0/1", arvalid, data_ok, stall); end
        next_cycle(); #1; sample_counts();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h0040_0004) begin failures++; $display("FAIL b2b_ar2 arvalid=%b araddr=%h exp=1/00400004", arvalid, araddr); end
        next_cycle(); #1; sample_counts();
        next_cycle(); #1; sample_counts();
        checks++; if (data_ok !== 1'b1 || rdata_o !== 32'h2222_2222) begin failures++; $display("FAIL b2b_dok2 data_ok=%b rdata_o=%h exp=1/22222222", data_ok, rdata_o); end
        req = 1'b0; rvalid = 1'b0; arready = 1'b0;
        next_cycle(); #1; sample_counts();
        checks++; if (hs_count !== 2 || dok_count !== 2) begin failures++; $display("FAIL b2b_counts hs=%0d dok=%0d exp=2/2", hs_count, dok_count); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_back_pressure();
        test_error();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_bridge.md
AXI_RD_BRIDGE -- requirements
Module: axi_rd_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, width of request and AXI read addresses.
REQ-002 Parameter DATA_W, default 32, width of read data.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port req  input  1  fetch request from the upstream PC register stage, level-held until serviced.
REQ-006 Port addr  input  ADDR_W  fetch address; valid while req=1.
REQ-007 Port cancel  input  1  discard the result of the in-flight transaction (pipeline flush).
REQ-008 Port stall  output  1  holds the upstream PC register while a fetch is pending.
REQ-009 Port data_ok  output  1  one-cycle pulse; rdata_o valid.
REQ-010 Port rdata_o  output  DATA_W  returned read data.
REQ-011 Port err  output  1  one-cycle pulse with data_ok when rresp != 0.
REQ-012 Port arvalid  output  1  AXI address valid.
REQ-013 Port arready  input  1  AXI address ready.
REQ-014 Port araddr  output  ADDR_W  AXI read address, registered.
REQ-015 Port arlen  output  8  constant 0, single beat.
REQ-016 Port arsize  output  3  constant 3'b010, 4 bytes.
REQ-017 Port rvalid  input  1  AXI read data valid.
REQ-018 Port rready  output  1  AXI read data ready.
REQ-019 Port rdata  input  DATA_W  AXI read data.
REQ-020 Port rresp  input  2  AXI read response.

Function
REQ-021 The FSM SHALL have three states: IDLE, ADDR, DATA.
REQ-022 In IDLE with req=1 and data_ok=0, addr SHALL be captured into araddr and the state SHALL move to ADDR.
REQ-023 In IDLE with data_ok=1, req SHALL be ignored, because it still belongs to the completed fetch.
REQ-024 In ADDR, arvalid SHALL be 1 and araddr SHALL remain stable; arready=1 SHALL move the state to DATA.
REQ-025 arvalid SHALL be registered and SHALL never deassert before arready is seen.
REQ-026 In DATA, rready SHALL be 1; rvalid=1 SHALL capture rdata into rdata_o and return the state to IDLE; rvalid is ignored in every other state.
REQ-027 data_ok SHALL pulse in the cycle after the rvalid&rready handshake unless the transaction is cancelled.
REQ-028 err SHALL pulse with data_ok when rresp != 0.
REQ-029 stall SHALL be combinational: (state != IDLE) | (req & ~data_ok).
REQ-030 With a zero-wait slave, minimum latency SHALL be 3 cycles: req at cycle 0 -> arvalid at 1 -> rready at 2 -> data_ok at 3.
REQ-031 cancel in ADDR or DATA SHALL set a cancelled flag.
- The AXI transaction SHALL still complete normally.
- data_ok and err SHALL be suppressed for that transaction.
- The flag SHALL clear on return to IDLE.
REQ-032 cancel in IDLE SHALL have no effect.
REQ-033 A simultaneous cancel and rvalid in DATA SHALL suppress data_ok.
REQ-034 rdata_o SHALL hold its last value until the next successful capture.
REQ-035 At most one AXI read SHALL be outstanding at any time.

Reset
REQ-036 On rst=1, the state SHALL be IDLE, the cancelled flag 0, and arvalid, rready, data_ok, err, araddr and rdata_o all 0, asynchronously.
REQ-037 Reset mid-transaction SHALL abandon the transaction; a late rvalid after reset SHALL be ignored because rready=0 in IDLE.

Verification
REQ-038 Zero-wait read: req=1, addr=0xBFC00000; arready=1 immediately; rvalid with rdata=0x3C08BFC0 -> araddr=0xBFC00000, data_ok at cycle 3, rdata_o=0x3C08BFC0, stall low in that cycle.
REQ-039 Back-pressure: arready held 0 for 4 cycles, then rvalid delayed 3 cycles -> arvalid and araddr stable throughout, stall=1 throughout, exactly one data_ok.
REQ-040 Error: rresp=2'b10 with rdata=0xDEADBEEF -> data_ok=1, err=1 in the same cycle, each for one cycle.
REQ-041 Cancel: cancel pulsed in DATA before rvalid -> rready still asserted, no data_ok, rdata_o unchanged; the next req is serviced normally.
REQ-042 Reset: rst asserted while in DATA -> all outputs 0 immediately; a later rvalid=1 causes no data_ok.
REQ-043 Back-to-back: req held high across two addresses, 0x00400000 then 0x00400004 -> two separate AR handshakes, second arvalid no earlier than the cycle after the first data_ok.
